// File: rtl/decode_stage.sv
// Purpose: MIPS instruction decode with a registered ID/EX output, load-use and HI/LO interlocks.
// Latency: 1 cycle from acceptance (in_valid & in_ready) to out_valid.
// Backpressure: out_valid & !out_ready holds all outputs and drops in_ready; the HI/LO counter keeps counting.
//
// Ports: clock/reset (sync, active-high); in_valid/in_ready/in_pc/in_insn from fetch;
//        s1/s2 -> register file read addresses, rs_data/rt_data <- read data (both combinational);
//        out_* : registered decoded instruction with out_valid/out_ready handshake.
// Optional feature: define DECODE_LOAD_USE_INTERLOCK_EN to insert one bubble on a load-use hazard.

module decode_stage #(
    parameter int DATA_W     = 32,
    parameter int MULDIV_LAT = 4
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [31:0]       in_pc,
    input  logic [31:0]       in_insn,
    output logic [4:0]        s1,
    output logic [4:0]        s2,
    input  logic [DATA_W-1:0] rs_data,
    input  logic [DATA_W-1:0] rt_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [31:0]       out_pc,
    output logic [DATA_W-1:0] out_rA,
    output logic [DATA_W-1:0] out_rB,
    output logic [DATA_W-1:0] out_imm,
    output logic [4:0]        out_shamt,
    output logic [4:0]        out_dst,
    output logic [5:0]        out_aluop,
    output logic              out_br,
    output logic              out_jp,
    output logic              out_aluinb,
    output logic              out_dmwe,
    output logic              out_rwe,
    output logic              out_rwd,
    output logic              out_unsigned,
    output logic              out_illegal
);

    localparam logic [5:0] OP_ADD  = 6'd0,  OP_SUB  = 6'd1,  OP_MULT = 6'd2,  OP_DIV  = 6'd3;
    localparam logic [5:0] OP_MFHI = 6'd4,  OP_MFLO = 6'd5,  OP_SLT  = 6'd6,  OP_SLL  = 6'd7;
    localparam logic [5:0] OP_SLLV = 6'd8,  OP_SRL  = 6'd9,  OP_SRLV = 6'd10, OP_SRA  = 6'd11;
    localparam logic [5:0] OP_SRAV = 6'd12, OP_AND  = 6'd13, OP_OR   = 6'd14, OP_XOR  = 6'd15;
    localparam logic [5:0] OP_NOR  = 6'd16, OP_JALR = 6'd17, OP_JR   = 6'd18, OP_LW   = 6'd19;
    localparam logic [5:0] OP_SW   = 6'd20, OP_LB   = 6'd21, OP_LUI  = 6'd22, OP_SB   = 6'd23;
    localparam logic [5:0] OP_LBU  = 6'd24, OP_BEQ  = 6'd25, OP_BNE  = 6'd26, OP_BGTZ = 6'd27;
    localparam logic [5:0] OP_BLEZ = 6'd28, OP_BLTZ = 6'd29, OP_BGEZ = 6'd30, OP_J    = 6'd31;
    localparam logic [5:0] OP_JAL  = 6'd32, OP_NOP  = 6'd33;

    localparam int CW = (MULDIV_LAT > 0) ? $clog2(MULDIV_LAT + 1) : 1;

    logic [5:0]        opcode, funct;
    logic [4:0]        rt_f, rd_f;
    logic [3:0]        pc_hi;
    logic [DATA_W-1:0] imm_sext, imm_zext, imm_lui, jtarget;

    assign opcode = in_insn[31:26];
    assign funct  = in_insn[5:0];
    assign rt_f   = in_insn[20:16];
    assign rd_f   = in_insn[15:11];
    assign s1     = in_insn[25:21];
    assign s2     = in_insn[20:16];

    // Top nibble of pc+4: a carry reaches bit 28 only when pc[27:2] is all ones.
    assign pc_hi    = in_pc[31:28] + {3'b000, &in_pc[27:2]};
    assign imm_sext = DATA_W'($signed(in_insn[15:0]));
    assign imm_zext = DATA_W'(in_insn[15:0]);
    assign imm_lui  = DATA_W'({in_insn[15:0], 16'h0000});
    assign jtarget  = DATA_W'({pc_hi, in_insn[25:0], 2'b00});

    logic [5:0]        d_aluop;
    logic [4:0]        d_dst;
    logic [DATA_W-1:0] d_imm;
    logic              d_br, d_jp, d_aluinb, d_dmwe, d_rwe, d_rwd, d_uns, d_ill;

    always_comb begin
        d_aluop  = OP_NOP;
        d_dst    = rt_f;
        d_imm    = imm_sext;
        d_br     = 1'b0;
        d_jp     = 1'b0;
        d_aluinb = 1'b0;
        d_dmwe   = 1'b0;
        d_rwe    = 1'b0;
        d_rwd    = 1'b0;
        d_uns    = 1'b0;
        d_ill    = 1'b0;
        if (in_insn == 32'h0) begin
            // canonical NOP: defaults already describe it
        end else if (opcode == 6'h00) begin
            d_dst = rd_f;
            case (funct)
                6'h00: {d_aluop, d_rwe} = {OP_SLL, 1'b1};
                6'h02: {d_aluop, d_rwe} = {OP_SRL, 1'b1};
                6'h03: {d_aluop, d_rwe} = {OP_SRA, 1'b1};
                6'h04: {d_aluop, d_rwe} = {OP_SLLV, 1'b1};
                6'h06: {d_aluop, d_rwe} = {OP_SRLV, 1'b1};
                6'h07: {d_aluop, d_rwe} = {OP_SRAV, 1'b1};
                6'h08: {d_aluop, d_jp} = {OP_JR, 1'b1};
                6'h09: {d_aluop, d_jp, d_rwe} = {OP_JALR, 2'b11};
                6'h10: {d_aluop, d_rwe} = {OP_MFHI, 1'b1};
                6'h12: {d_aluop, d_rwe} = {OP_MFLO, 1'b1};
                6'h18: d_aluop = OP_MULT;
                6'h19: {d_aluop, d_uns} = {OP_MULT, 1'b1};
                6'h1A: d_aluop = OP_DIV;
                6'h1B: {d_aluop, d_uns} = {OP_DIV, 1'b1};
                6'h20: {d_aluop, d_rwe} = {OP_ADD, 1'b1};
                6'h21: {d_aluop, d_rwe, d_uns} = {OP_ADD, 2'b11};
                6'h22: {d_aluop, d_rwe} = {OP_SUB, 1'b1};
                6'h23: {d_aluop, d_rwe, d_uns} = {OP_SUB, 2'b11};
                6'h24: {d_aluop, d_rwe} = {OP_AND, 1'b1};
                6'h25: {d_aluop, d_rwe} = {OP_OR, 1'b1};
                6'h26: {d_aluop, d_rwe} = {OP_XOR, 1'b1};
                6'h27: {d_aluop, d_rwe} = {OP_NOR, 1'b1};
                6'h2A: {d_aluop, d_rwe} = {OP_SLT, 1'b1};
                6'h2B: {d_aluop, d_rwe, d_uns} = {OP_SLT, 2'b11};
                default: d_ill = 1'b1;
            endcase
        end else if (opcode == 6'h1C && funct == 6'h02) begin
            // MUL goes through the HI/LO multiplier like MULT
            d_dst   = rd_f;
            d_aluop = OP_MULT;
        end else if (opcode == 6'h01) begin
            case (rt_f)
                5'd0:    {d_aluop, d_br} = {OP_BLTZ, 1'b1};
                5'd1:    {d_aluop, d_br} = {OP_BGEZ, 1'b1};
                default: d_ill = 1'b1;
            endcase
        end else begin
            case (opcode)
                6'h02: begin {d_aluop, d_jp} = {OP_J, 1'b1}; d_imm = jtarget; end
                6'h03: begin
                    {d_aluop, d_jp, d_rwe} = {OP_JAL, 2'b11};
                    d_dst = 5'd31;
                    d_imm = jtarget;
                end
                6'h04: {d_aluop, d_br} = {OP_BEQ, 1'b1};
                6'h05: {d_aluop, d_br} = {OP_BNE, 1'b1};
                6'h06: {d_aluop, d_br} = {OP_BLEZ, 1'b1};
                6'h07: {d_aluop, d_br} = {OP_BGTZ, 1'b1};
                6'h08: {d_aluop, d_rwe, d_aluinb} = {OP_ADD, 2'b11};
                6'h09: {d_aluop, d_rwe, d_aluinb} = {OP_ADD, 2'b11};
                6'h0A: {d_aluop, d_rwe, d_aluinb} = {OP_SLT, 2'b11};
                6'h0B: {d_aluop, d_rwe, d_aluinb, d_uns} = {OP_SLT, 3'b111};
                6'h0C: begin {d_aluop, d_rwe, d_aluinb} = {OP_AND, 2'b11}; d_imm = imm_zext; end
                6'h0D: begin {d_aluop, d_rwe, d_aluinb} = {OP_OR, 2'b11};  d_imm = imm_zext; end
                6'h0E: begin {d_aluop, d_rwe, d_aluinb} = {OP_XOR, 2'b11}; d_imm = imm_zext; end
                6'h0F: begin {d_aluop, d_rwe, d_aluinb} = {OP_LUI, 2'b11}; d_imm = imm_lui; end
                6'h20: {d_aluop, d_rwe, d_rwd, d_aluinb} = {OP_LB, 3'b111};
                6'h23: {d_aluop, d_rwe, d_rwd, d_aluinb} = {OP_LW, 3'b111};
                6'h24: {d_aluop, d_rwe, d_rwd, d_aluinb, d_uns} = {OP_LBU, 4'b1111};
                6'h28: {d_aluop, d_dmwe, d_aluinb} = {OP_SB, 2'b11};
                6'h2B: {d_aluop, d_dmwe, d_aluinb} = {OP_SW, 2'b11};
                default: d_ill = 1'b1;
            endcase
        end
    end

    // Hazard logic
    logic          is_muldiv, is_hilo, hilo_busy, load_use, stall, advance, accept;
    logic [CW-1:0] hilo_cnt;

    assign is_muldiv = (d_aluop == OP_MULT) | (d_aluop == OP_DIV);
    assign is_hilo   = is_muldiv | (d_aluop == OP_MFHI) | (d_aluop == OP_MFLO);
    assign hilo_busy = (hilo_cnt != '0) & is_hilo;

`ifdef DECODE_LOAD_USE_INTERLOCK_EN
    // The load sitting in ID/EX has not produced data yet; one bubble lets it reach the forward point.
    assign load_use = out_valid & out_rwd & out_rwe & (out_dst != 5'd0)
                    & ((out_dst == s1) | (out_dst == s2));
`else
    assign load_use = 1'b0;
`endif

    assign stall    = in_valid & (load_use | hilo_busy);
    assign advance  = out_ready | ~out_valid;
    assign in_ready = advance & ~stall;
    assign accept   = in_valid & in_ready;

    always_ff @(posedge clock) begin
        if (reset) begin
            out_valid    <= 1'b0;
            out_pc       <= '0;
            out_rA       <= '0;
            out_rB       <= '0;
            out_imm      <= '0;
            out_shamt    <= '0;
            out_dst      <= '0;
            out_aluop    <= OP_NOP;
            out_br       <= 1'b0;
            out_jp       <= 1'b0;
            out_aluinb   <= 1'b0;
            out_dmwe     <= 1'b0;
            out_rwe      <= 1'b0;
            out_rwd      <= 1'b0;
            out_unsigned <= 1'b0;
            out_illegal  <= 1'b0;
            hilo_cnt     <= '0;
        end else begin
            if (advance) begin
                // A stall or an empty input becomes a bubble; the payload fields keep their old values.
                out_valid <= accept;
                if (accept) begin
                    out_pc       <= in_pc;
                    out_rA       <= rs_data;
                    out_rB       <= rt_data;
                    out_imm      <= d_imm;
                    out_shamt    <= in_insn[10:6];
                    out_dst      <= d_dst;
                    out_aluop    <= d_aluop;
                    out_br       <= d_br;
                    out_jp       <= d_jp;
                    out_aluinb   <= d_aluinb;
                    out_dmwe     <= d_dmwe;
                    out_rwe      <= d_rwe;
                    out_rwd      <= d_rwd;
                    out_unsigned <= d_uns;
                    out_illegal  <= d_ill;
                end
            end
            if (accept & is_muldiv)
                hilo_cnt <= CW'(MULDIV_LAT);
            else if (hilo_cnt != '0)
                hilo_cnt <= hilo_cnt - CW'(1);
        end
    end

endmodule

// File: tb/tb_decode_stage.sv
module tb_decode_stage;

    localparam int LAT = 4;
`ifdef DECODE_LOAD_USE_INTERLOCK_EN
    localparam bit LU_EN = 1'b1;
`else
    localparam bit LU_EN = 1'b0;
`endif

    logic        clock, reset, in_valid, in_ready, out_valid, out_ready;
    logic [31:0] in_pc, in_insn, rs_data, rt_data, out_pc, out_rA, out_rB, out_imm;
    logic [4:0]  s1, s2, out_shamt, out_dst;
    logic [5:0]  out_aluop;
    logic        out_br, out_jp, out_aluinb, out_dmwe, out_rwe, out_rwd, out_unsigned, out_illegal;

    decode_stage #(.DATA_W(32), .MULDIV_LAT(LAT)) dut (
        .clock(clock), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .in_pc(in_pc), .in_insn(in_insn), .s1(s1), .s2(s2),
        .rs_data(rs_data), .rt_data(rt_data), .out_valid(out_valid), .out_ready(out_ready),
        .out_pc(out_pc), .out_rA(out_rA), .out_rB(out_rB), .out_imm(out_imm),
        .out_shamt(out_shamt), .out_dst(out_dst), .out_aluop(out_aluop),
        .out_br(out_br), .out_jp(out_jp), .out_aluinb(out_aluinb), .out_dmwe(out_dmwe),
        .out_rwe(out_rwe), .out_rwd(out_rwd), .out_unsigned(out_unsigned), .out_illegal(out_illegal)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    typedef struct packed {
        logic [31:0] pc, ra, rb, imm;
        logic [4:0]  shamt, dst;
        logic [5:0]  aluop;
        logic        br, jp, aluinb, dmwe, rwe, rwd, uns, ill;
    } exp_t;

    // Encoding rule: (word & mask) == val selects it; flag letters give its properties.
    // W rwe, L rwd, I aluinb, S dmwe, B br, J jp, U unsigned,
    // D dst=rd, R dst=31, Z zero-ext imm, H imm<<16, T jump target.
    typedef struct {
        logic [31:0] mask;
        logic [31:0] val;
        int          op;
        string       fl;
    } rule_t;
    rule_t rules[$];

    int   n_cmp = 0, n_bad = 0;
    int   cyc = 0, last_md = -1000, st;
    exp_t m;
    logic m_valid, m_known = 1'b0, obs_rdy;

    function automatic void add_rule(input logic [31:0] mk, input logic [31:0] v, input int op, input string fl);
        rule_t r;
        r.mask = mk; r.val = v; r.op = op; r.fl = fl;
        rules.push_back(r);
    endfunction

    function automatic void add_r(input logic [5:0] fn, input int op, input string fl);
        add_rule(32'hFC00003F, {26'h0, fn}, op, fl);
    endfunction

    function automatic void add_i(input logic [5:0] opc, input int op, input string fl);
        add_rule(32'hFC000000, {opc, 26'h0}, op, fl);
    endfunction

    task automatic build_rules();
        add_rule(32'hFFFFFFFF, 32'h0, 33, "");
        add_r(6'h00, 7, "WD");   add_r(6'h02, 9, "WD");   add_r(6'h03, 11, "WD");
        add_r(6'h04, 8, "WD");   add_r(6'h06, 10, "WD");  add_r(6'h07, 12, "WD");
        add_r(6'h08, 18, "JD");  add_r(6'h09, 17, "JWD"); add_r(6'h10, 4, "WD");
        add_r(6'h12, 5, "WD");   add_r(6'h18, 2, "D");    add_r(6'h19, 2, "DU");
        add_r(6'h1A, 3, "D");    add_r(6'h1B, 3, "DU");   add_r(6'h20, 0, "WD");
        add_r(6'h21, 0, "WDU");  add_r(6'h22, 1, "WD");   add_r(6'h23, 1, "WDU");
        add_r(6'h24, 13, "WD");  add_r(6'h25, 14, "WD");  add_r(6'h26, 15, "WD");
        add_r(6'h27, 16, "WD");  add_r(6'h2A, 6, "WD");   add_r(6'h2B, 6, "WDU");
        add_rule(32'hFC00003F, 32'h70000002, 2, "D");
        add_rule(32'hFC1F0000, 32'h04000000, 29, "B");
        add_rule(32'hFC1F0000, 32'h04010000, 30, "B");
        add_i(6'h02, 31, "JT");  add_i(6'h03, 32, "JWRT");
        add_i(6'h04, 25, "B");   add_i(6'h05, 26, "B");   add_i(6'h06, 28, "B");
        add_i(6'h07, 27, "B");   add_i(6'h08, 0, "WI");   add_i(6'h09, 0, "WI");
        add_i(6'h0A, 6, "WI");   add_i(6'h0B, 6, "WIU");  add_i(6'h0C, 13, "WIZ");
        add_i(6'h0D, 14, "WIZ"); add_i(6'h0E, 15, "WIZ"); add_i(6'h0F, 22, "WIH");
        add_i(6'h20, 21, "WLI"); add_i(6'h23, 19, "WLI"); add_i(6'h24, 24, "WLIU");
        add_i(6'h28, 23, "SI");  add_i(6'h2B, 20, "SI");
    endtask

    function automatic exp_t ref_decode(input logic [31:0] pc, input logic [31:0] w);
        exp_t        d;
        int          hit;
        string       f;
        logic [31:0] pc4;
        d   = '0;
        hit = -1;
        for (int i = 0; i < rules.size(); i++)
            if (hit < 0 && (w & rules[i].mask) == rules[i].val) hit = i;
        d.dst = w[20:16];
        d.imm = {{16{w[15]}}, w[15:0]};
        if (hit < 0) begin
            d.aluop = 6'd33;
            d.ill   = 1'b1;
            if (w[31:26] == 6'h00) d.dst = w[15:11];
            return d;
        end
        d.aluop = 6'(rules[hit].op);
        f = rules[hit].fl;
        for (int k = 0; k < f.len(); k++) begin
            case (f[k])
                "W": d.rwe = 1'b1;
                "L": d.rwd = 1'b1;
                "I": d.aluinb = 1'b1;
                "S": d.dmwe = 1'b1;
                "B": d.br = 1'b1;
                "J": d.jp = 1'b1;
                "U": d.uns = 1'b1;
                "D": d.dst = w[15:11];
                "R": d.dst = 5'd31;
                "Z": d.imm = {16'h0, w[15:0]};
                "H": d.imm = {w[15:0], 16'h0};
                "T": begin pc4 = pc + 32'd4; d.imm = {pc4[31:28], w[25:0], 2'b00}; end
                default: ;
            endcase
        end
        return d;
    endfunction

    function automatic exp_t observed();
        exp_t o;
        o.pc = out_pc; o.ra = out_rA; o.rb = out_rB; o.imm = out_imm;
        o.shamt = out_shamt; o.dst = out_dst; o.aluop = out_aluop;
        o.br = out_br; o.jp = out_jp; o.aluinb = out_aluinb; o.dmwe = out_dmwe;
        o.rwe = out_rwe; o.rwd = out_rwd; o.uns = out_unsigned; o.ill = out_illegal;
        return o;
    endfunction

    task automatic chk(input string tag, input logic [159:0] obs, input logic [159:0] exp_v);
        n_cmp++;
        assert (obs === exp_v) else begin
            n_bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
        end
    endtask

    task automatic drive(input logic v, input logic [31:0] pc, input logic [31:0] w, input logic ordy);
        in_valid  = v;
        in_pc     = pc;
        in_insn   = w;
        out_ready = ordy;
        rs_data   = $urandom;
        rt_data   = $urandom;
    endtask

    // One clock: check combinational outputs, advance the model at the edge, check registers.
    task automatic tick();
        exp_t d;
        logic adv, lu, busy, stl, rdy;
        #1;
        d       = ref_decode(in_pc, in_insn);
        d.pc    = in_pc;
        d.ra    = rs_data;
        d.rb    = rt_data;
        d.shamt = in_insn[10:6];
        adv  = out_ready || !m_valid;
        lu   = LU_EN && m_valid && m.rwd && m.rwe && m.dst != 5'd0
               && (m.dst == in_insn[25:21] || m.dst == in_insn[20:16]);
        busy = (cyc - last_md <= LAT) && (d.aluop inside {6'd2, 6'd3, 6'd4, 6'd5});
        stl  = in_valid && (lu || busy);
        rdy  = adv && !stl;
        obs_rdy = in_ready;
        chk("s1", s1, in_insn[25:21]);
        chk("s2", s2, in_insn[20:16]);
        if (m_known) chk("in_ready", in_ready, rdy);
        @(posedge clock);
        if (reset) begin
            m_known = 1'b1;
            m_valid = 1'b0;
            m       = '0;
            m.aluop = 6'd33;
            last_md = -1000;
        end else if (adv) begin
            if (in_valid && !stl) begin
                m       = d;
                m_valid = 1'b1;
                if (d.aluop inside {6'd2, 6'd3}) last_md = cyc;
            end else begin
                m_valid = 1'b0;
            end
        end
        cyc++;
        #1;
        chk("out_valid", out_valid, m_valid);
        chk("out_aluop", out_aluop, m.aluop);
        chk("out_fields", observed(), m);
        @(negedge clock);
    endtask

    task automatic run_until_accept(input int budget, output int stalls);
        stalls = 0;
        for (int k = 0; k < budget; k++) begin
            tick();
            if (obs_rdy) return;
            stalls++;
        end
        chk("accept_within_budget", obs_rdy, 1);
    endtask

    function automatic logic [31:0] rand_insn();
        logic [31:0] w;
        int          sel, i;
        sel = $urandom_range(0, 99);
        w   = $urandom;
        if (sel < 3) return 32'h0;
        if (sel < 12) return w;
        w[25:21] = 5'($urandom_range(0, 3));
        w[20:16] = 5'($urandom_range(0, 3));
        w[15:11] = 5'($urandom_range(0, 3));
        i = $urandom_range(1, rules.size() - 1);
        return (w & ~rules[i].mask) | rules[i].val;
    endfunction

    initial begin
        build_rules();
        m = '0; m_valid = 1'b0;
        reset = 1'b1;
        drive(1'b0, 32'h0, 32'h0, 1'b1);
        @(negedge clock);
        tick();
        tick();
        reset = 1'b0;
        chk("reset_out_valid", out_valid, 0);
        chk("reset_out_aluop", out_aluop, 33);

        // ADD r3 = r1 + r2
        drive(1'b1, 32'h100, 32'h00221820, 1'b1);
        #1;
        chk("add_s1", s1, 1);
        chk("add_s2", s2, 2);
        tick();
        chk("add_aluop", out_aluop, 0);
        chk("add_dst", out_dst, 3);
        chk("add_rwe", out_rwe, 1);
        chk("add_aluinb", out_aluinb, 0);

        // LW r2 then ADD using r2
        drive(1'b1, 32'h104, 32'h8C220004, 1'b1);
        tick();
        drive(1'b1, 32'h108, 32'h00421820, 1'b1);
        run_until_accept(4, st);
        chk("load_use_bubbles", st, LU_EN ? 1 : 0);

        // MULT then MFLO: HI/LO interlock
        drive(1'b1, 32'h10C, 32'h00220018, 1'b1);
        tick();
        drive(1'b1, 32'h110, 32'h00002012, 1'b1);
        run_until_accept(10, st);
        chk("mflo_stall_cycles", st, LAT);
        chk("mflo_aluop", out_aluop, 5);
        chk("mflo_rwe", out_rwe, 1);
        chk("mflo_dst", out_dst, 4);

        // JAL
        drive(1'b1, 32'h00400000, 32'h0C100004, 1'b1);
        tick();
        chk("jal_imm", out_imm, 32'h00400010);
        chk("jal_dst", out_dst, 31);
        chk("jal_rwe", out_rwe, 1);
        chk("jal_jp", out_jp, 1);
        chk("jal_aluop", out_aluop, 32);

        // Immediates and illegal
        drive(1'b1, 32'h200, 32'h3022FFFF, 1'b1);
        tick();
        chk("andi_imm", out_imm, 32'h0000FFFF);
        chk("andi_unsigned", out_unsigned, 0);
        drive(1'b1, 32'h204, 32'h2022FFFF, 1'b1);
        tick();
        chk("addi_imm", out_imm, 32'hFFFFFFFF);
        drive(1'b1, 32'h208, 32'hFC000000, 1'b1);
        tick();
        chk("illegal_flag", out_illegal, 1);
        chk("illegal_rwe", out_rwe, 0);

        // Back-pressure while the HI/LO counter runs down
        drive(1'b1, 32'h300, 32'h00220018, 1'b1);
        tick();
        drive(1'b1, 32'h304, 32'h00002012, 1'b0);
        repeat (3) begin
            tick();
            chk("bp_in_ready", obs_rdy, 0);
            chk("bp_out_valid", out_valid, 1);
            chk("bp_out_aluop", out_aluop, 2);
        end
        drive(1'b1, 32'h304, 32'h00002012, 1'b1);
        run_until_accept(4, st);
        chk("bp_counter_boundary_stall", st, 1);

        // Reset in the middle of a held stall clears the counter
        drive(1'b1, 32'h400, 32'h00220018, 1'b1);
        tick();
        drive(1'b1, 32'h404, 32'h00001010, 1'b0);
        tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("reset2_out_valid", out_valid, 0);
        chk("reset2_out_aluop", out_aluop, 33);
        drive(1'b1, 32'h408, 32'h00002012, 1'b1);
        #1;
        chk("reset2_counter_clear", in_ready, 1);
        tick();

        // Random traffic against the model
        for (int c = 0; c < 3000; c++) begin
            reset = ($urandom_range(0, 199) == 0);
            drive($urandom_range(0, 9) < 7, $urandom & ~32'h3, rand_insn(), $urandom_range(0, 9) < 7);
            tick();
        end
        reset = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/decode_stage.md
# decode_stage

Pipelined, parametrised MIPS instruction decode stage with a registered ID/EX output. It sits between fetch and the ALU/memory path. It drives register-file read addresses and latches decoded control, operands and immediates into an output register under a valid/ready handshake. It stalls on load-use hazards and on an in-flight multi-cycle MULT/DIV, resolves the destination register internally, and flags illegal opcodes.

## Interface
**Parameters**
- `DATA_W`, 32: operand and immediate width (≥32).
- `MULDIV_LAT`, 4: HI/LO busy cycles after a MULT/DIV issues; 0 disables the HI/LO interlock.

**Ports** (clock and reset first)
- `clock`  in  1: sole clock; all state updates on its rising edge.
- `reset`  in  1: synchronous, active-high.
- `in_valid`  in  1: `in_pc`/`in_insn` hold a valid instruction.
- `in_ready`  out  1: instruction accepted this cycle when high with `in_valid`.
- `in_pc`  in  32: instruction address.
- `in_insn`  in  32: instruction word.
- `s1`, `s2`  out  5: combinational register-file read addresses (rs, rt), derived from `in_insn`.
- `rs_data`, `rt_data`  in  DATA_W: combinational register-file read data.
- `out_valid`  out  1: output register holds a valid decoded instruction.
- `out_ready`  in  1: downstream accepts.
- `out_pc`  out  32: latched PC.
- `out_rA`, `out_rB`  out  DATA_W: latched operands.
- `out_imm`  out  DATA_W: extended immediate or jump target.
- `out_shamt`  out  5: `insn[10:6]`.
- `out_dst`  out  5: resolved write register.
- `out_aluop`  out  6: ALU operation code.
- `out_br`, `out_jp`, `out_aluinb`, `out_dmwe`, `out_rwe`, `out_rwd`, `out_unsigned`, `out_illegal`  out  1: decoded control flags.

## Operation
- **aluop codes:** ADD 0, SUB 1, MULT 2, DIV 3, MFHI 4, MFLO 5, SLT 6, SLL 7, SLLV 8, SRL 9, SRLV 10, SRA 11, SRAV 12, AND 13, OR 14, XOR 15, NOR 16, JALR 17, JR 18, LW 19, SW 20, LB 21, LUI 22, SB 23, LBU 24, BEQ 25, BNE 26, BGTZ 27, BLEZ 28, BLTZ 29, BGEZ 30, J 31, JAL 32, NOP 33.
- **Decode classes:**
  - R-type: opcode 0, or opcode 0x1C with funct 0x02 (MUL → MULT).
  - REGIMM: opcode 1, keyed on rt.
  - J/JAL: opcode 2/3.
  - Everything else: I-type.
- **Register addresses:** `s1`=insn[25:21] and `s2`=insn[20:16] unconditionally. Unused operands are don't-care.
- **out_dst:**
  - R-type: rd.
  - I-type: rt.
  - JAL: 31.
- **out_rwe = 1** for ALU R-type ops, MFHI/MFLO, JALR, ALU immediates, LUI, loads, and JAL. It is 0 for everything else.
- **out_rwd = 1** for loads only.
- **out_aluinb = 1** for immediate ALU ops, loads, and stores.
- **out_unsigned = 1** for ADDU, SUBU, SLTU, SLTIU, MULTU, DIVU, LBU.
- **out_imm:**
  - ANDI/ORI/XORI: zero-extended.
  - LUI: imm<<16.
  - J/JAL: {pc+4[31:28], insn[25:0], 2'b00}, zero-extended.
  - Otherwise: sign-extended.
- **Illegal/unknown encodings:** all-zero insn word → NOP, `out_illegal`=0. Unknown opcode, funct, or REGIMM rt → aluop NOP, `out_illegal`=1, `out_rwe`=`out_dmwe`=`out_br`=`out_jp`=0.
- **advance** = `out_ready` | !`out_valid`.
- **stall** = `in_valid` & (load-use | hilo_busy).
- **in_ready** = advance & !stall.
- **On advance:**
  - If `in_valid` & !stall: load the decoded instruction and set `out_valid`=1.
  - Otherwise: clear `out_valid` (bubble). The bubble's other outputs hold.
- **If !advance:** all outputs hold.
- **hilo counter:** loads `MULDIV_LAT` when MULT/DIV/MUL is accepted. Otherwise it decrements while nonzero. hilo_busy = (counter≠0) & (incoming is MFHI/MFLO/MULT/DIV/MUL).

## Timing
- **Latency:** 1 cycle from acceptance to `out_valid`.
- `s1`/`s2` are combinational from `in_insn`.
- **Reset:**
  - `out_valid`=0, `out_aluop`=33.
  - All other outputs 0.
  - hilo counter 0.
  - Reset overrides stall and back-pressure; an instruction held mid-stall is discarded.
- **Back-pressure:** `out_valid`=1 & `out_ready`=0 → outputs stable, `in_ready`=0, hilo counter still decrements.
- **Simultaneous load-use and hilo stall:** a single bubble per cycle; stall persists until both clear.
- **Counter boundary:** an instruction arriving when counter=1 is stalled; it is accepted the cycle the counter reads 0.

## Configuration
- **`DECODE_LOAD_USE_INTERLOCK_EN` defined:** load-use = `out_valid` & `out_rwd` & `out_rwe` & (`out_dst`≠0) & (`out_dst`==`s1` | `out_dst`==`s2`). This inserts exactly one bubble.
- **Undefined:** load-use is tied to 0; no load-use bubbles are inserted.

## Test plan
- ADD 0x00221820, `out_ready`=1 → `s1`=1, `s2`=2; next cycle `out_aluop`=0, `out_dst`=3, `out_rwe`=1, `out_aluinb`=0.
- LW 0x8C220004 then ADD 0x00421820 (interlock enabled) → one cycle with `in_ready`=0 and a bubble (`out_valid`=0); the ADD issues on the following cycle. With the macro undefined, no bubble.
- MULT 0x00220018 then MFLO 0x00002012, `MULDIV_LAT`=4 → MFLO held with `in_ready`=0 for 4 cycles, then issues with `out_aluop`=5, `out_rwe`=1, `out_dst`=4.
- JAL 0x0C100004 at `in_pc`=0x00400000 → `out_imm`=0x00400010, `out_dst`=31, `out_rwe`=1, `out_jp`=1, `out_aluop`=32.
- Immediates:
  - ANDI 0x3022FFFF → `out_imm`=0x0000FFFF, `out_unsigned`=0.
  - ADDI 0x2022FFFF → `out_imm`=0xFFFFFFFF.
  - Illegal 0xFC000000 → `out_illegal`=1, `out_rwe`=0.
- `out_ready`=0 for 3 cycles with `out_valid`=1 → outputs stable; assert `reset` mid-hold → next cycle `out_valid`=0, `out_aluop`=33, counter 0.
